// File: rtl/kid_motion_ctrl.sv
// kid_motion_ctrl: per-frame kid sprite motion sequencer; define HOLD_JUMP_EN for variable jump height
module kid_motion_ctrl #(
  parameter int KID_W    = 21,
  parameter int KID_H    = 21,
  parameter int START_X  = 200,
  parameter int START_Y  = 500,
  parameter int WALK_SPD = 3,
  parameter int JUMP_V   = 8,
  parameter int DJUMP_V  = 7,
  parameter int VMAX     = 9,
  parameter int SETTLE   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic [3:0] is_collide,
  output logic [9:0] kid_t,
  output logic [9:0] kid_b,
  output logic [9:0] kid_l,
  output logic [9:0] kid_r,
  output logic       on_ground,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);
  typedef enum logic [2:0] {IDLE, CALC, HWAIT, HSTEP, VWAIT, VSTEP, DONE} state_t;
  localparam logic signed [5:0] VY_MAX  = 6'(VMAX);
  localparam logic signed [5:0] VY_JMP  = -6'(JUMP_V);
  localparam logic signed [5:0] VY_DJMP = -6'(DJUMP_V);
  state_t state, next;
  logic signed [5:0] vy, vy_base, vy_calc;
  logic [5:0] vcnt, vcnt_calc;
  logic [3:0] hcnt, wcnt;
  logic [9:0] hstep_d, vstep_d;
  logic hleft, djump_avail, jump_pend, jump_q, settled, h_block, v_block;
`ifdef HOLD_JUMP_EN
  logic rel_pend;
  // a jump-key release while rising halves the upward speed at the next CALC
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rel_pend <= 1'b0;
    else rel_pend <= (!key_jump && jump_q && vy < 0) || (rel_pend && state != CALC);
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // next state: each wait state lasts SETTLE cycles so the detector sees the moved box
  always_comb begin
    settled = (int'(wcnt) + 1 >= SETTLE);
    next = state;
    case (state)
      IDLE:    next = frame_tick ? CALC : IDLE;
      CALC:    next = HWAIT;
      HWAIT:   next = (hcnt == '0) ? VWAIT : settled ? HSTEP : HWAIT;
      HSTEP:   next = HWAIT;
      VWAIT:   next = (vcnt == '0) ? DONE : settled ? VSTEP : VWAIT;
      VSTEP:   next = VWAIT;
      DONE:    next = settled ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  // status outputs
  always_comb begin
    busy = state != IDLE;
    overrun = frame_tick && busy;
  end
  // velocity update, step directions and blocking conditions
  always_comb begin
    vy_base = vy;
`ifdef HOLD_JUMP_EN
    if (rel_pend && vy < 0) vy_base = vy >>> 1;
`endif
    vy_calc = (jump_pend && on_ground) ? VY_JMP :
              (jump_pend && djump_avail) ? VY_DJMP :
              (vy_base >= VY_MAX) ? VY_MAX : vy_base + 6'sd1;
    vcnt_calc = vy_calc[5] ? 6'(-vy_calc) : 6'(vy_calc);
    h_block = hleft ? (is_collide[2] || kid_l == '0) : (is_collide[3] || kid_r == '1);
    v_block = vy[5] ? (is_collide[0] || kid_t == '0) : (is_collide[1] || kid_b == '1);
    hstep_d = hleft ? '1 : 10'd1;
    vstep_d = vy[5] ? '1 : 10'd1;
  end
  // frame datapath: jump latch, velocity, step counters and the kid box
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kid_l <= 10'(START_X);
      kid_t <= 10'(START_Y);
      kid_r <= 10'(START_X + KID_W - 1);
      kid_b <= 10'(START_Y + KID_H - 1);
      vy <= '0;
      vcnt <= '0;
      hcnt <= '0;
      wcnt <= '0;
      hleft <= 1'b0;
      on_ground <= 1'b0;
      djump_avail <= 1'b1;
      jump_pend <= 1'b0;
      jump_q <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      jump_q <= key_jump;
      jump_pend <= (key_jump && !jump_q) || (jump_pend && state != CALC);
      wcnt <= (next != state) ? '0 : wcnt + 1'b1;
      frame_done <= state == DONE && settled;
      case (state)
        CALC: begin
          vy <= vy_calc;
          vcnt <= vcnt_calc;
          djump_avail <= (jump_pend && on_ground) || (djump_avail && !jump_pend);
          hleft <= key_left && !key_right;
          hcnt <= (key_left != key_right) ? 4'(WALK_SPD) : '0;
        end
        HSTEP:
          if (h_block) hcnt <= '0;
          else begin
            kid_l <= kid_l + hstep_d;
            kid_r <= kid_r + hstep_d;
            hcnt <= hcnt - 1'b1;
          end
        VSTEP:
          if (v_block) begin
            vy <= '0;
            vcnt <= '0;
          end else begin
            kid_t <= kid_t + vstep_d;
            kid_b <= kid_b + vstep_d;
            vcnt <= vcnt - 1'b1;
          end
        DONE:
          if (settled) begin
            on_ground <= is_collide[1];
            if (is_collide[1]) begin
              djump_avail <= 1'b1;
              if (vy > 0) vy <= '0;
            end
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_kid_motion_ctrl.sv
// tb_kid_motion_ctrl: frame-level reference model of the kid motion rules with a simple world detector
module tb_kid_motion_ctrl;
  localparam int WALK = 3, JV = 8, DJV = 7, VMAX = 9;
  logic clk = 0, rst_n = 0, frame_tick = 0, key_left = 0, key_right = 0, key_jump = 0;
  logic [3:0] is_collide;
  logic [9:0] kid_t, kid_b, kid_l, kid_r;
  logic on_ground, busy, frame_done, overrun;
  logic [40:0] obs;
  int n_cmp = 0, n_bad = 0;
  int wall_l = -1, wall_r = 2000, ceil_y = -1, floor_y = 2000;
  int m_l, m_t, m_vy;
  bit m_og, m_dj, m_pend, m_rel;

  kid_motion_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .key_left(key_left), .key_right(key_right),
    .key_jump(key_jump), .is_collide(is_collide), .kid_t(kid_t), .kid_b(kid_b), .kid_l(kid_l),
    .kid_r(kid_r), .on_ground(on_ground), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always_comb is_collide = {int'(kid_r) >= wall_r, int'(kid_l) <= wall_l, int'(kid_b) >= floor_y, int'(kid_t) <= ceil_y};
  assign obs = {kid_l, kid_t, kid_r, kid_b, on_ground};

  function automatic logic [40:0] exp_box();
    return {10'(m_l), 10'(m_t), 10'(m_l + 20), 10'(m_t + 20), m_og};
  endfunction

  task automatic do_reset();
    rst_n = 0; key_left = 0; key_right = 0; key_jump = 0; frame_tick = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    m_l = 200; m_t = 500; m_vy = 0; m_og = 0; m_dj = 1; m_pend = 0; m_rel = 0;
  endtask

  task automatic set_jump(input bit j);
    if (j && !key_jump) m_pend = 1;
    if (!j && key_jump && m_vy < 0) m_rel = 1;
    key_jump = j;
  endtask

  // one frame of the rules: velocity, then clipped horizontal and vertical travel, then ground check
  task automatic model_frame(input bit l, input bit r);
    int vb, d;
    vb = m_vy;
`ifdef HOLD_JUMP_EN
    if (m_rel && vb < 0) vb = vb >>> 1;
`endif
    if (m_pend && m_og) begin m_vy = -JV; m_dj = 1; end
    else if (m_pend && m_dj) begin m_vy = -DJV; m_dj = 0; end
    else m_vy = (vb + 1 > VMAX) ? VMAX : vb + 1;
    m_pend = 0; m_rel = 0;
    if (l && !r) begin
      d = m_l - (wall_l > 0 ? wall_l : 0);
      m_l -= (d < 0) ? 0 : (d > WALK ? WALK : d);
    end
    if (r && !l) begin
      d = (wall_r < 1023 ? wall_r : 1023) - (m_l + 20);
      m_l += (d < 0) ? 0 : (d > WALK ? WALK : d);
    end
    if (m_vy < 0) begin
      d = m_t - (ceil_y > 0 ? ceil_y : 0);
      if (d < 0) d = 0;
      if (-m_vy > d) begin m_t -= d; m_vy = 0; end else m_t += m_vy;
    end else if (m_vy > 0) begin
      d = (floor_y < 1023 ? floor_y : 1023) - (m_t + 20);
      if (d < 0) d = 0;
      if (m_vy > d) begin m_t += d; m_vy = 0; end else m_t += m_vy;
    end
    m_og = (m_t + 20 >= floor_y);
    if (m_og) begin m_dj = 1; if (m_vy > 0) m_vy = 0; end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300 && !frame_done; k++) @(negedge clk);
    n_cmp++;
    if (frame_done !== 1'b1) begin n_bad++; $display("FAIL frame_timeout: frame_done=%b required 1", frame_done); end
  endtask

  task automatic run_frame(input bit l, input bit r, input bit j, input bit same);
    @(negedge clk);
    key_left = l; key_right = r; set_jump(j);
    if (!same) @(negedge clk);
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    wait_done();
    model_frame(l, r);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({obs, busy, frame_done, overrun} !== {10'd200, 10'd500, 10'd220, 10'd520, 1'b0, 3'b000}) begin
      n_bad++;
      $display("FAIL reset: l/t/r/b=%0d/%0d/%0d/%0d og=%b busy=%b fd=%b ov=%b required 200/500/220/520 0 0 0 0",
               kid_l, kid_t, kid_r, kid_b, on_ground, busy, frame_done, overrun);
    end
  endtask

  task automatic test_fall();
    do_reset(); floor_y = 1000;
    for (int i = 0; i < 12; i++) begin
      run_frame(0, 0, 0, 0);
      n_cmp++;
      if (obs !== exp_box()) begin
        n_bad++;
        $display("FAIL fall[%0d]: l/t=%0d/%0d og=%b required %0d/%0d og=%b", i, kid_l, kid_t, on_ground, m_l, m_t, m_og);
      end
    end
    n_cmp++;
    if (kid_b !== 10'd592) begin n_bad++; $display("FAIL fall_cap: kid_b=%0d required 592", kid_b); end
  endtask

  task automatic test_floor();
    do_reset(); floor_y = 540;
    for (int i = 0; i < 8; i++) begin
      run_frame(0, 0, 0, 0);
      n_cmp++;
      if (obs !== exp_box()) begin
        n_bad++;
        $display("FAIL floor[%0d]: l/t=%0d/%0d og=%b required %0d/%0d og=%b", i, kid_l, kid_t, on_ground, m_l, m_t, m_og);
      end
    end
    n_cmp++;
    if ({kid_b, on_ground} !== {10'd540, 1'b1}) begin n_bad++; $display("FAIL floor_land: kid_b=%0d og=%b required 540 1", kid_b, on_ground); end
  endtask

  task automatic test_jump();
    bit seq [14] = '{1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      run_frame(0, 0, seq[i], 0);
      n_cmp++;
      if (obs !== exp_box()) begin
        n_bad++;
        $display("FAIL jump[%0d]: l/t=%0d/%0d og=%b required %0d/%0d og=%b", i, kid_l, kid_t, on_ground, m_l, m_t, m_og);
      end
      if (i == 0) begin
        n_cmp++;
        if (kid_t !== 10'd512) begin n_bad++; $display("FAIL jump_first: kid_t=%0d required 512", kid_t); end
      end
    end
  endtask

  task automatic test_hold();
    int exp_t;
    do_reset(); floor_y = 540;
    repeat (8) run_frame(0, 0, 0, 0);
    run_frame(0, 0, 1, 0);
    run_frame(0, 0, 1, 0);
    run_frame(0, 0, 1, 0);
    run_frame(0, 0, 0, 0);
`ifdef HOLD_JUMP_EN
    exp_t = 497;
`else
    exp_t = 494;
`endif
    n_cmp++;
    if ({obs, int'(kid_t)} !== {exp_box(), exp_t}) begin
      n_bad++;
      $display("FAIL hold_release: kid_t=%0d required %0d (model %0d)", kid_t, exp_t, m_t);
    end
  endtask

  task automatic test_walls();
    do_reset(); floor_y = 540;
    repeat (8) run_frame(0, 0, 0, 0);
    wall_r = 221;
    run_frame(0, 1, 0, 0);
    n_cmp++;
    if ({obs, kid_l} !== {exp_box(), 10'd201}) begin n_bad++; $display("FAIL wall_right: kid_l=%0d required 201", kid_l); end
    run_frame(1, 1, 0, 0);
    n_cmp++;
    if ({obs, kid_l} !== {exp_box(), 10'd201}) begin n_bad++; $display("FAIL both_keys: kid_l=%0d required 201", kid_l); end
    wall_r = 2000;
    for (int i = 0; i < 75; i++) begin
      run_frame(i < 2 ? 1'b0 : 1'b1, i < 2 ? 1'b1 : 1'b0, 0, 0);
      n_cmp++;
      if (obs !== exp_box()) begin
        n_bad++;
        $display("FAIL walk[%0d]: l/t=%0d/%0d required %0d/%0d", i, kid_l, kid_t, m_l, m_t);
      end
    end
    n_cmp++;
    if (kid_l !== 10'd0) begin n_bad++; $display("FAIL left_edge: kid_l=%0d required 0", kid_l); end
  endtask

  task automatic test_ceiling();
    do_reset(); floor_y = 1000; ceil_y = 500;
    run_frame(0, 0, 1, 0);
    n_cmp++;
    if ({obs, kid_t} !== {exp_box(), 10'd500}) begin n_bad++; $display("FAIL ceiling_block: kid_t=%0d required 500", kid_t); end
    run_frame(0, 0, 0, 0);
    n_cmp++;
    if ({obs, kid_t} !== {exp_box(), 10'd501}) begin n_bad++; $display("FAIL ceiling_fall: kid_t=%0d required 501", kid_t); end
    ceil_y = -1;
  endtask

  task automatic test_overrun();
    do_reset(); floor_y = 1000;
    @(negedge clk); frame_tick = 1;
    @(negedge clk); frame_tick = 0;
    @(negedge clk); frame_tick = 1;
    #1;
    n_cmp++;
    if ({overrun, busy} !== 2'b11) begin n_bad++; $display("FAIL overrun_pulse: overrun=%b busy=%b required 1 1", overrun, busy); end
    @(negedge clk); frame_tick = 0;
    wait_done();
    model_frame(0, 0);
    n_cmp++;
    if ({obs, overrun} !== {exp_box(), 1'b0}) begin
      n_bad++;
      $display("FAIL overrun_frame: t=%0d ov=%b required %0d 0", kid_t, overrun, m_t);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); floor_y = 540;
    repeat (8) run_frame(0, 0, 0, 0);
    run_frame(0, 0, 1, 1);
    n_cmp++;
    if ({obs, kid_t} !== {exp_box(), 10'd512}) begin n_bad++; $display("FAIL same_cycle_jump: kid_t=%0d required 512", kid_t); end
  endtask

  task automatic test_midreset();
    do_reset(); floor_y = 1000;
    @(negedge clk); key_right = 1; frame_tick = 1;
    @(negedge clk); frame_tick = 0;
    repeat (6) @(negedge clk);
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if ({obs, busy} !== {10'd200, 10'd500, 10'd220, 10'd520, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL midreset: l/t=%0d/%0d busy=%b required 200/500 0", kid_l, kid_t, busy);
    end
    do_reset();
    run_frame(0, 1, 0, 0);
    n_cmp++;
    if (obs !== exp_box()) begin n_bad++; $display("FAIL after_reset: l/t=%0d/%0d required %0d/%0d", kid_l, kid_t, m_l, m_t); end
  endtask

  task automatic test_random();
    do_reset(); wall_l = 100; wall_r = 600; ceil_y = 300; floor_y = 700;
    for (int i = 0; i < 80; i++) begin
      run_frame(1'($urandom), 1'($urandom), ($urandom % 3) == 0, 1'($urandom));
      n_cmp++;
      if (obs !== exp_box()) begin
        n_bad++;
        $display("FAIL random[%0d]: l/t=%0d/%0d og=%b required %0d/%0d og=%b", i, kid_l, kid_t, on_ground, m_l, m_t, m_og);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fall();
    test_floor();
    test_jump();
    test_hold();
    test_walls();
    test_ceiling();
    test_overrun();
    test_back_to_back();
    test_midreset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
